// File: rtl/case_pkg.sv
// Shared encodings and ASCII constants for the streaming case converter.
package case_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  typedef enum logic {
    FRAME_IDLE   = 1'b0,
    FRAME_ACTIVE = 1'b1
  } frame_state_e;

  localparam logic [7:0] ASCII_UC_A = 8'h41;
  localparam logic [7:0] ASCII_UC_Z = 8'h5A;
  localparam logic [7:0] ASCII_LC_A = 8'h61;
  localparam logic [7:0] ASCII_LC_Z = 8'h7A;
  localparam int         CASE_BIT   = 5;

endpackage

// File: rtl/case_lane.sv
// One-character case converter: classifies the byte and flips the case bit
// when the mode asks for it.
module case_lane
  import case_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [7:0] ch,
  output logic [7:0] converted,
  output logic       changed
);

  logic is_upper;
  logic is_lower;
  logic flip;

  always_comb begin
    // Bytes with bit7 set fall outside both ranges, so they never convert.
    is_upper = (ch >= ASCII_UC_A) && (ch <= ASCII_UC_Z);
    is_lower = (ch >= ASCII_LC_A) && (ch <= ASCII_LC_Z);
    flip     = 1'b0;
    case (mode_e'(mode))
      MODE_UPPER:  flip = is_lower;
      MODE_LOWER:  flip = is_upper;
      MODE_TOGGLE: flip = is_upper | is_lower;
      default:     flip = 1'b0;
    endcase
    converted           = ch;
    converted[CASE_BIT] = ch[CASE_BIT] ^ flip;
    changed             = flip;
  end

endmodule

// File: rtl/case_convert_stream.sv
// Streaming ASCII case converter: LANES characters per beat, registered
// output with a one-entry skid buffer, per-frame mode latch and count.
//
// state        | meaning
// FRAME_IDLE   | waiting for the first beat of a frame; mode is taken live
// FRAME_ACTIVE | mid-frame; the latched mode is used until in_last is accepted
module case_convert_stream
  import case_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_last,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     out_count
);

  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + 1;

  frame_state_e state, state_nxt;
  logic [1:0]         mode_q;
  logic [1:0]         lane_mode;
  logic [CNT_W-1:0]   total;
  logic [8*LANES-1:0] conv_data;
  logic [LANES-1:0]   changed;
  logic [PW-1:0]      beat_pop;
  logic [SW-1:0]      sum;
  logic [CNT_W-1:0]   beat_count;
  logic               in_fire;

  logic               skid_valid;
  logic [8*LANES-1:0] skid_data;
  logic               skid_last;
  logic [CNT_W-1:0]   skid_count;

  assign in_ready  = !skid_valid && !rst;
  assign in_fire   = in_valid && in_ready;
  assign lane_mode = (state == FRAME_IDLE) ? mode : mode_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    case_lane u_lane (
      .mode      (lane_mode),
      .ch        (in_data[8*g +: 8]),
      .converted (conv_data[8*g +: 8]),
      .changed   (changed[g])
    );
  end

  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_pop = beat_pop + PW'(changed[i]);
    end
    sum        = SW'(total) + SW'(beat_pop);
    beat_count = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    if (in_fire) begin
      state_nxt = in_last ? FRAME_IDLE : FRAME_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FRAME_IDLE;
      mode_q <= MODE_PASS;
      total  <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        if (state == FRAME_IDLE) mode_q <= mode;
        total <= in_last ? '0 : beat_count;
      end
    end
  end

  // Output register takes priority from the skid; new beats only land in the
  // skid when the output register is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_count  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_count <= '0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_data   <= skid_data;
        out_last   <= skid_last;
        out_count  <= skid_count;
        skid_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (out_valid && !out_ready) begin
        skid_valid <= 1'b1;
        skid_data  <= conv_data;
        skid_last  <= in_last;
        skid_count <= beat_count;
      end else begin
        out_valid <= 1'b1;
        out_data  <= conv_data;
        out_last  <= in_last;
        out_count <= beat_count;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_case_convert_stream.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_case_convert_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] out_count;

  logic        v4 = 1'b0;
  logic        in_ready4;
  logic [31:0] d4 = '0;
  logic        l4 = 1'b0;
  logic [1:0]  m4 = 2'b01;
  logic        valid4;
  logic        oready4 = 1'b1;
  logic [31:0] data4;
  logic        last4;
  logic [3:0]  count4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  case_convert_stream #(.LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_count(out_count)
  );

  case_convert_stream #(.LANES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(in_ready4),
    .in_data(d4), .in_last(l4), .mode(m4),
    .out_valid(valid4), .out_ready(oready4), .out_data(data4),
    .out_last(last4), .out_count(count4)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          count;
  } beat_t;

  beat_t       exp_q[$];
  logic        m_active = 1'b0;
  logic [1:0]  m_mode = 2'b00;
  int          m_total = 0;

  function automatic void model_beat(input logic [31:0] d, input logic [1:0] m,
                                     output logic [31:0] o, output int c);
    int b;
    o = '0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      b = int'(d[8*i +: 8]);
      if (b >= 97 && b <= 122 && (m == 2'd1 || m == 2'd3)) begin
        b = b - 32; c++;
      end else if (b >= 65 && b <= 90 && (m == 2'd2 || m == 2'd3)) begin
        b = b + 32; c++;
      end
      o[8*i +: 8] = 8'(b);
    end
  endfunction

  always @(negedge clk) begin
    beat_t       e;
    logic [31:0] o;
    int          c;
    logic [1:0]  mm;
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0;
      m_total  = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_unexpected got data=%h (no beat expected)", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last || out_count !== 16'(e.count)) begin
            n_bad++;
            $display("FAIL scoreboard got data=%h last=%b count=%0d want data=%h last=%b count=%0d",
                     out_data, out_last, out_count, e.data, e.last, e.count);
          end
        end
      end
      if (in_valid && in_ready) begin
        mm = m_active ? m_mode : mode;
        m_mode = mm;
        model_beat(in_data, mm, o, c);
        m_total = m_total + c;
        if (m_total > 65535) m_total = 65535;
        e.data  = o;
        e.last  = in_last;
        e.count = m_total;
        exp_q.push_back(e);
        m_active = !in_last;
        if (in_last) m_total = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [1:0] m);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; mode = m;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        n_total++; n_bad++;
        $display("FAIL send_timeout got in_ready=0 want 1 within 20 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int cnt_exp[5] = '{4, 8, 12, 15, 15};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    send(32'h6C6C6548, 1'b1, 2'b01);
    chk("upper_data", out_data, 32'h4C4C4548);
    chk("upper_last", 32'(out_last), 32'd1);
    chk("upper_count", 32'(out_count), 32'd3);

    send(32'h7A314261, 1'b1, 2'b11);
    chk("toggle_data", out_data, 32'h5A316241);
    chk("toggle_count", 32'(out_count), 32'd3);
    send(32'h7A314261, 1'b1, 2'b00);
    chk("pass_data", out_data, 32'h7A314261);
    chk("pass_count", 32'(out_count), 32'd0);

    send(32'h7B604D40, 1'b1, 2'b01);
    chk("bound_upper", out_data, 32'h7B604D40);
    chk("bound_upper_cnt", 32'(out_count), 32'd0);
    send(32'h7B604D40, 1'b1, 2'b10);
    chk("bound_lower", out_data, 32'h7B606D40);
    chk("bound_lower_cnt", 32'(out_count), 32'd1);
    send(32'h7B604D40, 1'b1, 2'b11);
    chk("bound_toggle", out_data, 32'h7B606D40);
    chk("bound_toggle_cnt", 32'(out_count), 32'd1);
    for (int m = 1; m < 4; m++) begin
      send(32'hE1E1E1E1, 1'b1, 2'(m));
      chk("high_bit", out_data, 32'hE1E1E1E1);
      chk("high_bit_cnt", 32'(out_count), 32'd0);
    end

    send(32'h61616161, 1'b0, 2'b01);
    chk("latch_b1", out_data, 32'h41414141);
    send(32'h62626262, 1'b0, 2'b10);
    chk("latch_b2", out_data, 32'h42424242);
    chk("latch_b2_cnt", 32'(out_count), 32'd8);
    send(32'h63636363, 1'b1, 2'b10);
    chk("latch_b3", out_data, 32'h43434343);
    chk("latch_b3_cnt", 32'(out_count), 32'd12);
    send(32'h41414141, 1'b1, 2'b10);
    chk("next_frame_lower", out_data, 32'h61616161);
    chk("next_frame_cnt", 32'(out_count), 32'd4);

    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b0; mode = 2'b01; in_data = 32'h61626364;
    @(posedge clk); #1;
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_data", out_data, 32'h41424344);
    in_data = 32'h65666768; mode = 2'b10;
    @(posedge clk); #1;
    chk("bp_skid_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", out_data, 32'h41424344);
    in_data = 32'h696A6B6C; in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_c_wait", 32'(in_ready), 32'd0);
    chk("bp_stable", out_data, 32'h41424344);
    chk("bp_stable_cnt", 32'(out_count), 32'd4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b_data", out_data, 32'h45464748);
    chk("bp_b_cnt", 32'(out_count), 32'd8);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_c_data", out_data, 32'h494A4B4C);
    chk("bp_c_cnt", 32'(out_count), 32'd12);
    chk("bp_c_last", 32'(out_last), 32'd1);
    in_valid = 1'b0;

    in_valid = 1'b1; mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h41626344 + 32'(i);
      in_last = (i == 3);
      @(posedge clk); #1;
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    v4 = 1'b1; d4 = 32'h64636261; m4 = 2'b01;
    for (int i = 0; i < 5; i++) begin
      l4 = (i == 4);
      @(posedge clk); #1;
      chk("sat_count", 32'(count4), 32'(cnt_exp[i]));
      chk("sat_data", data4, 32'h44434241);
    end
    l4 = 1'b0;
    @(posedge clk); #1;

    send(32'h61616161, 1'b0, 2'b01);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_valid4", 32'(valid4), 32'd0);
    chk("midrst_count4", 32'(count4), 32'd0);
    rst = 1'b0; v4 = 1'b0;
    send(32'h41616161, 1'b1, 2'b10);
    chk("relatch_data", out_data, 32'h61616161);
    chk("relatch_count", 32'(out_count), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/case_convert_stream.md
Name: case_convert_stream

Overview:
- Streaming ASCII case converter that processes LANES characters per beat, with valid/ready handshakes on input and output.
- Supports four per-frame modes: pass, to-upper, to-lower and toggle. Keeps a saturating per-frame count of converted characters.
- Sits between the byte-stream source (UART/text buffer) and downstream consumers.
- Registered output with a skid buffer: full throughput, 1-cycle latency.

Parameters:
- LANES, 4, characters per beat; lane 0 at data[7:0] is the earliest character.
- CNT_W, 16, width of the converted-character counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_data  in  8*LANES  input characters.
- in_last  in  1  final beat of the frame.
- mode  in  2  00 pass, 01 upper, 10 lower, 11 toggle; sampled at frame start.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  8*LANES  converted characters.
- out_last  out  1  copy of in_last for this beat.
- out_count  out  CNT_W  cumulative converted-character count for the frame, including this beat.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, out_count=0, skid buffer empty, frame state "idle".
- in_ready is 0 while rst=1, and 1 in the first cycle after rst deasserts.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency: an accepted beat appears on out_* in the next cycle when the output register is free.
- Throughput: 1 beat/cycle while out_ready=1.
- Output stall: while out_valid=1 and out_ready=0, out_data, out_last and out_count stay stable.
- Skid buffer: one beat arriving during a stall goes to the skid register, and in_ready deasserts next cycle.
- Skid drain: when out_ready returns, the skid beat moves to the output register and in_ready reasserts next cycle.
- Ordering: beats are never dropped, duplicated or reordered.
- Mode latching: mode is latched on the first accepted beat after reset or after an accepted in_last beat. It is held until that frame's in_last beat is accepted. Changes to mode mid-frame are ignored.
- Per-lane character classes: lower = 0x61..0x7A, upper = 0x41..0x5A. Any byte with bit7=1 is never converted.
- Conversion flips bit 5 only:
  - upper mode flips lower-class characters;
  - lower mode flips upper-class characters;
  - toggle mode flips both classes;
  - pass mode flips nothing.
- All other bytes pass unchanged, including the boundary characters 0x40, 0x5B, 0x60 and 0x7B.
- Counting: the per-beat changed count is the popcount of changed lanes, 0..LANES.
  - out_count = previous frame total + beat count, saturating at 2^CNT_W-1; it never wraps.
  - The frame total clears after the in_last beat is accepted; the next frame starts from 0.
- Single-beat frame: in_last=1 on the first beat is legal; mode is latched and cleared in the same transfer.
- Simultaneous input and output transfer with the skid empty: the output register reloads directly, and in_ready stays 1.
- Reset mid-frame: all in-flight beats are discarded, counters clear, and mode is re-latched on the next accepted beat.

Decomposition:
- Shared package case_pkg holds:
  - mode encodings MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE;
  - the constants ASCII_UC_A=0x41, ASCII_UC_Z=0x5A, ASCII_LC_A=0x61, ASCII_LC_Z=0x7A, CASE_BIT=5.
- Sub-module case_lane: combinational, one character in, converted character plus a changed flag out. It takes the latched mode and is instantiated LANES times.
- The top level holds the handshake, skid register, mode latch and counter.

Test Plan:
- Mode upper, one beat in_data=0x6C6C6548 ("Hell"), in_last=1, out_ready=1 -> next cycle out_data=0x4C4C4548, out_last=1, out_count=3.
- Mode toggle, in_data=0x7A314261 ("aB1z") -> out_data=0x5A316241, out_count=3. In mode pass, the same input -> unchanged, out_count=0.
- Boundaries in upper, lower and toggle modes: 0x7B604D40 -> 0x7B606D40 only in lower and toggle (out_count=1), unchanged in upper. 0xE1E1E1E1 is unchanged in all modes.
- Backpressure: hold out_ready=0 and offer 3 beats A, B, C -> A is registered, B goes to skid, in_ready=0 while C waits. After release, A, B, C emerge in order on consecutive cycles with no loss.
- Mode 01 latched on beat 1, mode switched to 10 on beats 2-3 -> all 3 beats are upper-converted. The next frame uses mode 10.
- With CNT_W=4, 5 beats of "abcd" in upper mode -> out_count 4, 8, 12, 15, 15. Asserting rst mid-frame afterwards -> out_valid=0 and out_count=0 next cycle.
